axi4_ar_fifo: RTL and testbench
===============================

# axi4_ar_fifo

First-word-fall-through FIFO on the AXI4 read-address channel of the RAB slave port. It sits directly upstream of the AR sender stage. It decouples the external master's AR handshake from L1/L2 TLB lookup latency and the sender's back-pressure. Every accepted AR beat is stored whole and presented in order to the downstream stage, with a stable payload and a valid/ready handshake.

## Interface
Parameters:
- AXI_ADDR_WIDTH, 40, address width
- AXI_ID_WIDTH, 4, ID width
- AXI_USER_WIDTH, 4, user width
- BUFFER_DEPTH, 4, number of entries; power of two, >= 2

Ports:
- axi4_aclk  in  1  clock; all logic on the rising edge
- axi4_arstn  in  1  reset, asynchronous, active-low
- s_axi4_arid / araddr / arlen / arsize / arburst / arlock / arprot / arcache / aruser  in  ID/ADDR/8/3/2/1/3/4/USER  incoming AR payload
- s_axi4_arvalid  in  1  incoming AR valid
- s_axi4_arready  out  1  FIFO not full
- m_axi4_arid / araddr / arlen / arsize / arburst / arlock / arprot / arcache / aruser  out  same widths  head-entry payload to the AR sender
- m_axi4_arvalid  out  1  FIFO not empty
- m_axi4_arready  in  1  downstream accepts the head entry
- fill_level_o  out  $clog2(BUFFER_DEPTH)+1  current entry count, 0..BUFFER_DEPTH

## Operation
- **Storage and pointers:** BUFFER_DEPTH entries, each holding the full AR payload. Write pointer wr_ptr and read pointer rd_ptr are $clog2(BUFFER_DEPTH) bits wide. Register cnt is $clog2(BUFFER_DEPTH)+1 bits wide.
- **Push:** occurs when s_axi4_arvalid & s_axi4_arready. The payload is written at wr_ptr, then wr_ptr increments.
- **Pop:** occurs when m_axi4_arvalid & m_axi4_arready. rd_ptr increments.
- **Pointer wrap-around:** pointers wrap modulo BUFFER_DEPTH through natural overflow. No pointer comparison is used; full and empty are decided only from cnt.
- **Count update:** push only → cnt+1; pop only → cnt−1; push and pop together → cnt unchanged; neither → unchanged.
- **Ready/valid decode:** s_axi4_arready = (cnt != BUFFER_DEPTH). m_axi4_arvalid = (cnt != 0). Both are decoded combinationally from registered cnt only. There is no combinational path from any valid input to any ready output.
- **Full:** there is no pass-through. A pop in the same cycle does not re-enable arready; arready reasserts in the cycle after the pop.
- **Empty:** there is no bypass. A push into an empty FIFO appears on m_axi4_arvalid one cycle later.
- **Head output:** m_axi4_* payload = storage[rd_ptr]. It is stable while m_axi4_arvalid=1 and m_axi4_arready=0, which satisfies the AXI rule that valid must not be withdrawn.
- **Order:** entries leave in strict acceptance order. There is no ID-based reordering.
- **Pointer reset:** pointers and cnt reset to 0. Storage is reset to all-zero, so all m_axi4_* payload outputs read 0 after reset.
- **Reset values:** s_axi4_arready=1, m_axi4_arvalid=0, fill_level_o=0.
- **Reset mid-operation:** an asynchronous assertion immediately empties the FIFO. All stored beats are discarded and no beat is emitted.

## Timing
- Latency from input handshake to m_axi4_arvalid on an empty FIFO: 1 cycle.
- Sustained throughput: 1 beat/cycle when 0 < cnt < BUFFER_DEPTH and both sides are active.
- fill_level_o is registered and reflects cnt after the edge.
- s_axi4_arready falls in the cycle after the push that makes cnt=BUFFER_DEPTH.
- s_axi4_arready rises in the cycle after the first pop from full.
- Push while full (arvalid=1, arready=0): ignored, no state change. The master must hold the beat.
- Pop while empty: impossible, because m_axi4_arvalid=0.

## Test plan
- **Reset values:** release reset with no traffic → arready=1, m_arvalid=0, fill_level_o=0, m_araddr=0.
- **Single-beat latency:** push araddr=0x12_3400_0000, arid=3, arlen=7 with m_arready=0 → next cycle m_arvalid=1, m_araddr=0x12_3400_0000, m_arid=3, m_arlen=7, fill_level_o=1. Raise m_arready for one cycle → m_arvalid=0 next cycle.
- **Fill to full:** m_arready=0, push 4 beats with araddr 0x100..0x103 → arready=0 after the 4th, fill_level_o=4. A 5th beat held valid is not accepted. Pop once → arready=1 the following cycle, 5th beat accepted, fill_level_o=4.
- **Simultaneous push/pop:** with fill_level_o=2, push and pop in the same cycle → fill_level_o stays 2, and the head advances to the next-oldest entry.
- **Wrap-around and order:** stream 10 beats, arid 0..9, with random m_arready → output IDs appear in order 0..9, no duplicates or drops; pointers wrap twice.
- **Reset mid-operation:** with fill_level_o=3 and m_arready=0, assert axi4_arstn low asynchronously mid-cycle → m_arvalid=0 and fill_level_o=0 immediately, arready=1. After release, no stale beat is emitted.

Source files
------------

// File: rtl/axi4_ar_fifo.sv
// axi4_ar_fifo: first-word-fall-through FIFO on the AXI4 read-address channel.
// It decouples the master's AR handshake from downstream lookup latency and
// from back-pressure on the AR sender stage.
//
// Ports:
//   axi4_aclk, axi4_arstn    clock; asynchronous active-low reset
//   s_axi4_ar*               incoming AR beat (valid/ready slave side)
//   m_axi4_ar*               head entry presented to the AR sender (master side)
//   fill_level_o             registered entry count, 0..BUFFER_DEPTH
module axi4_ar_fifo #(
    parameter int unsigned AXI_ADDR_WIDTH = 40,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned BUFFER_DEPTH   = 4
) (
    input  logic                              axi4_aclk,
    input  logic                              axi4_arstn,

    input  logic [AXI_ID_WIDTH-1:0]           s_axi4_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]         s_axi4_araddr,
    input  logic [7:0]                        s_axi4_arlen,
    input  logic [2:0]                        s_axi4_arsize,
    input  logic [1:0]                        s_axi4_arburst,
    input  logic                              s_axi4_arlock,
    input  logic [2:0]                        s_axi4_arprot,
    input  logic [3:0]                        s_axi4_arcache,
    input  logic [AXI_USER_WIDTH-1:0]         s_axi4_aruser,
    input  logic                              s_axi4_arvalid,
    output logic                              s_axi4_arready,

    output logic [AXI_ID_WIDTH-1:0]           m_axi4_arid,
    output logic [AXI_ADDR_WIDTH-1:0]         m_axi4_araddr,
    output logic [7:0]                        m_axi4_arlen,
    output logic [2:0]                        m_axi4_arsize,
    output logic [1:0]                        m_axi4_arburst,
    output logic                              m_axi4_arlock,
    output logic [2:0]                        m_axi4_arprot,
    output logic [3:0]                        m_axi4_arcache,
    output logic [AXI_USER_WIDTH-1:0]         m_axi4_aruser,
    output logic                              m_axi4_arvalid,
    input  logic                              m_axi4_arready,

    output logic [$clog2(BUFFER_DEPTH):0]     fill_level_o
);

    localparam int unsigned PTR_W     = $clog2(BUFFER_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned PAYLOAD_W = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 8 + 3 + 2 + 1
                                        + 3 + 4 + AXI_USER_WIDTH;

    logic [PAYLOAD_W-1:0] storage [BUFFER_DEPTH];
    logic [PAYLOAD_W-1:0] wr_payload_c;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next_c;
    logic                 push_c;
    logic                 pop_c;

    // Full/empty come from the registered count only, so ready never depends on valid.
    assign s_axi4_arready = (cnt != CNT_W'(BUFFER_DEPTH));
    assign m_axi4_arvalid = (cnt != CNT_W'(0));

    assign push_c = s_axi4_arvalid & s_axi4_arready;
    assign pop_c  = m_axi4_arvalid & m_axi4_arready;

    assign wr_payload_c = {s_axi4_arid, s_axi4_araddr, s_axi4_arlen, s_axi4_arsize,
                           s_axi4_arburst, s_axi4_arlock, s_axi4_arprot,
                           s_axi4_arcache, s_axi4_aruser};

    // Head entry falls through; it only moves when rd_ptr advances on a pop.
    assign {m_axi4_arid, m_axi4_araddr, m_axi4_arlen, m_axi4_arsize, m_axi4_arburst,
            m_axi4_arlock, m_axi4_arprot, m_axi4_arcache, m_axi4_aruser} = storage[rd_ptr];

    assign fill_level_o = cnt;

    // Occupancy update.
    always_comb begin
        cnt_next_c = cnt;
        if (push_c && !pop_c) begin
            cnt_next_c = cnt + CNT_W'(1);
        end else if (pop_c && !push_c) begin
            cnt_next_c = cnt - CNT_W'(1);
        end
    end

    // Pointers and count; pointers wrap by natural overflow.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            cnt <= cnt_next_c;
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage, cleared on reset so the head reads zero when empty after reset.
    always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
        if (!axi4_arstn) begin
            for (int i = 0; i < int'(BUFFER_DEPTH); i++) begin
                storage[i] <= '0;
            end
        end else if (push_c) begin
            storage[wr_ptr] <= wr_payload_c;
        end
    end

endmodule

// File: tb/tb_axi4_ar_fifo.sv
module tb_axi4_ar_fifo;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic [3:0]  s_arid = '0;
    logic [39:0] s_araddr = '0;
    logic [7:0]  s_arlen = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [3:0]  m_arid;
    logic [39:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arlock;
    logic [2:0]  m_arprot;
    logic [3:0]  m_arcache;
    logic [3:0]  m_aruser;
    logic        m_arvalid;
    logic        m_arready = 1'b0;
    logic [2:0]  fill;

    int n_vec = 0;
    int n_miscomp = 0;

    always #5 clk = ~clk;

    axi4_ar_fifo dut (
        .axi4_aclk      (clk),
        .axi4_arstn     (arstn),
        .s_axi4_arid    (s_arid),
        .s_axi4_araddr  (s_araddr),
        .s_axi4_arlen   (s_arlen),
        .s_axi4_arsize  (3'd3),
        .s_axi4_arburst (2'd1),
        .s_axi4_arlock  (1'b0),
        .s_axi4_arprot  (3'd0),
        .s_axi4_arcache (4'd0),
        .s_axi4_aruser  (4'd0),
        .s_axi4_arvalid (s_arvalid),
        .s_axi4_arready (s_arready),
        .m_axi4_arid    (m_arid),
        .m_axi4_araddr  (m_araddr),
        .m_axi4_arlen   (m_arlen),
        .m_axi4_arsize  (m_arsize),
        .m_axi4_arburst (m_arburst),
        .m_axi4_arlock  (m_arlock),
        .m_axi4_arprot  (m_arprot),
        .m_axi4_arcache (m_arcache),
        .m_axi4_aruser  (m_aruser),
        .m_axi4_arvalid (m_arvalid),
        .m_axi4_arready (m_arready),
        .fill_level_o   (fill)
    );

    typedef struct {
        logic        sv;
        logic [3:0]  id;
        logic [39:0] addr;
        logic [7:0]  len;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic [2:0]  e_fill;
        logic        e_pl;
        logic [39:0] e_addr;
        logic [3:0]  e_id;
        logic [7:0]  e_len;
    } vec_t;

    vec_t vt [21];

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        if (act !== exp) begin
            n_miscomp++;
            $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic sv, input logic [3:0] id, input logic [39:0] addr,
                                input logic [7:0] len, input logic mr, input logic e_sr,
                                input logic e_mv, input logic [2:0] e_fill, input logic e_pl,
                                input logic [39:0] e_addr, input logic [3:0] e_id,
                                input logic [7:0] e_len);
        vec_t v;
        v.sv = sv; v.id = id; v.addr = addr; v.len = len; v.mr = mr;
        v.e_sr = e_sr; v.e_mv = e_mv; v.e_fill = e_fill; v.e_pl = e_pl;
        v.e_addr = e_addr; v.e_id = e_id; v.e_len = e_len;
        return v;
    endfunction

    initial begin
        // Expected values describe outputs just before the rising edge that applies the inputs.
        //            sv id addr            len mr  sr mv fill pl e_addr          e_id e_len
        vt[0]  = mk(0, 0, 40'h0,          0, 0,  1, 0, 0,  1, 40'h0,          0,   0);
        vt[1]  = mk(1, 3, 40'h12_3400_0000, 7, 0,  1, 0, 0,  1, 40'h0,          0,   0);
        vt[2]  = mk(0, 0, 40'h0,          0, 0,  1, 1, 1,  1, 40'h12_3400_0000, 3, 7);
        vt[3]  = mk(0, 0, 40'h0,          0, 1,  1, 1, 1,  1, 40'h12_3400_0000, 3, 7);
        vt[4]  = mk(0, 0, 40'h0,          0, 0,  1, 0, 0,  0, 40'h0,          0,   0);
        vt[5]  = mk(1, 0, 40'h100,        0, 0,  1, 0, 0,  0, 40'h0,          0,   0);
        vt[6]  = mk(1, 1, 40'h101,        1, 0,  1, 1, 1,  1, 40'h100,        0,   0);
        vt[7]  = mk(1, 2, 40'h102,        2, 0,  1, 1, 2,  1, 40'h100,        0,   0);
        vt[8]  = mk(1, 3, 40'h103,        3, 0,  1, 1, 3,  1, 40'h100,        0,   0);
        vt[9]  = mk(1, 4, 40'h104,        4, 0,  0, 1, 4,  1, 40'h100,        0,   0);
        vt[10] = mk(1, 4, 40'h104,        4, 0,  0, 1, 4,  1, 40'h100,        0,   0);
        vt[11] = mk(1, 4, 40'h104,        4, 1,  0, 1, 4,  1, 40'h100,        0,   0);
        vt[12] = mk(1, 4, 40'h104,        4, 0,  1, 1, 3,  1, 40'h101,        1,   1);
        vt[13] = mk(0, 0, 40'h0,          0, 0,  0, 1, 4,  1, 40'h101,        1,   1);
        vt[14] = mk(0, 0, 40'h0,          0, 1,  0, 1, 4,  1, 40'h101,        1,   1);
        vt[15] = mk(0, 0, 40'h0,          0, 1,  1, 1, 3,  1, 40'h102,        2,   2);
        vt[16] = mk(1, 5, 40'h105,        5, 1,  1, 1, 2,  1, 40'h103,        3,   3);
        vt[17] = mk(0, 0, 40'h0,          0, 0,  1, 1, 2,  1, 40'h104,        4,   4);
        vt[18] = mk(0, 0, 40'h0,          0, 1,  1, 1, 2,  1, 40'h104,        4,   4);
        vt[19] = mk(0, 0, 40'h0,          0, 1,  1, 1, 1,  1, 40'h105,        5,   5);
        vt[20] = mk(0, 0, 40'h0,          0, 0,  1, 0, 0,  0, 40'h0,          0,   0);

        repeat (3) @(negedge clk);
        arstn = 1'b1;

        // Table-driven directed vectors.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            s_arvalid = vt[i].sv;
            s_arid    = vt[i].id;
            s_araddr  = vt[i].addr;
            s_arlen   = vt[i].len;
            m_arready = vt[i].mr;
            #1;
            n_vec++;
            check("s_arready", i, 64'(s_arready), 64'(vt[i].e_sr));
            check("m_arvalid", i, 64'(m_arvalid), 64'(vt[i].e_mv));
            check("fill_level", i, 64'(fill), 64'(vt[i].e_fill));
            if (vt[i].e_pl) begin
                check("m_araddr", i, 64'(m_araddr), 64'(vt[i].e_addr));
                check("m_arid", i, 64'(m_arid), 64'(vt[i].e_id));
                check("m_arlen", i, 64'(m_arlen), 64'(vt[i].e_len));
            end
        end

        // Wrap-around and ordering: 10 beats with random downstream back-pressure.
        begin
            int sent = 0;
            int rcvd = 0;
            int cyc  = 0;
            while (rcvd < 10 && cyc < 300) begin
                @(negedge clk);
                s_arvalid = (sent < 10);
                s_arid    = 4'(sent);
                s_araddr  = 40'h200 + 40'(sent);
                s_arlen   = 8'(sent);
                m_arready = 1'($urandom_range(0, 1));
                #1;
                if (m_arvalid && m_arready) begin
                    n_vec++;
                    check("stream_id", rcvd, 64'(m_arid), 64'(rcvd));
                    check("stream_addr", rcvd, 64'(m_araddr), 64'h200 + 64'(rcvd));
                    rcvd++;
                end
                if (s_arvalid && s_arready) sent++;
                cyc++;
            end
            n_vec++;
            check("stream_count", 0, 64'(rcvd), 64'd10);
            @(negedge clk);
            s_arvalid = 1'b0;
            m_arready = 1'b0;
            #1;
            n_vec++;
            check("stream_drained", 0, 64'(m_arvalid), 64'd0);
        end

        // Asynchronous reset mid-operation with three beats queued.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_arvalid = 1'b1;
            s_arid    = 4'(k + 8);
            s_araddr  = 40'h300 + 40'(k);
        end
        @(negedge clk);
        s_arvalid = 1'b0;
        #1;
        n_vec++;
        check("pre_reset_fill", 0, 64'(fill), 64'd3);
        @(posedge clk);
        #3;
        arstn = 1'b0;
        #1;
        n_vec++;
        check("rst_m_arvalid", 0, 64'(m_arvalid), 64'd0);
        check("rst_fill", 0, 64'(fill), 64'd0);
        check("rst_s_arready", 0, 64'(s_arready), 64'd1);
        @(negedge clk);
        arstn = 1'b1;
        m_arready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            check("post_rst_no_beat", k, 64'(m_arvalid), 64'd0);
            check("post_rst_fill", k, 64'(fill), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
        $finish;
    end

endmodule
